// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared arbiter state and grant types
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        grant_i = 1'b0,
        grant_d = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational grant selection; round-robin under ARBITER_ROUND_ROBIN_EN
module arb_pick
    import arbiter_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_grant_t last_served,
    output arb_grant_t grant
);

`ifdef ARBITER_ROUND_ROBIN_EN
    always_comb begin
        grant = grant_i;
        if (i_req && d_req)
            grant = (last_served == grant_d) ? grant_i : grant_d;
        else if (d_req)
            grant = grant_d;
    end
`else
    logic unused_last_served;
    assign unused_last_served = last_served;

    // Data cache has fixed priority; i_req only matters when d_req is low.
    always_comb begin
        grant = grant_i;
        if (d_req)
            grant = grant_d;
        else if (i_req)
            grant = grant_i;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter onto one physical memory port (ARBITER_ROUND_ROBIN_EN selects fairness)
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    arb_grant_t last_served;
    arb_grant_t grant;
    logic       d_req;

    assign d_req = d_read | d_write;

    arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_served (last_served),
        .grant       (grant)
    );

    // The pmem command registers double as the request latch and are
    // cleared on completion, so IDLE always presents an all-zero command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= grant_i;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            pmem_addr   <= '0;
            pmem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read || d_req) begin
                        last_served <= grant;
                        if (grant == grant_d) begin
                            state      <= SERVE_D;
                            pmem_read  <= ~d_write;
                            pmem_write <= d_write;
                            pmem_addr  <= d_addr;
                            pmem_wdata <= d_write ? d_wdata : '0;
                        end else begin
                            state      <= SERVE_I;
                            pmem_read  <= 1'b1;
                            pmem_write <= 1'b0;
                            pmem_addr  <= i_addr;
                            pmem_wdata <= '0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        pmem_addr  <= '0;
                        pmem_wdata <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    pmem_addr  <= '0;
                    pmem_wdata <= '0;
                end
            endcase
        end
    end

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = (d_resp && pmem_read) ? pmem_rdata : '0;

endmodule
